// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch / program-counter stage.
package fetch_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned LUT_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Branch-target table: register array with synchronous write and combinational read.
module branch_lut #(
  parameter int unsigned PC_W  = fetch_pkg::PC_W,
  parameter int unsigned LUT_W = fetch_pkg::LUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [LUT_W-1:0] wr_idx,
  input  logic [PC_W-1:0]  wr_data,
  input  logic [LUT_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_data
);
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 2 ** LUT_W;

  logic [PC_W-1:0] mem [DEPTH];

  // Table storage: cleared on reset, written one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, run/done state machine and saturating cycle counter.
module fetch_ctrl #(
  parameter int unsigned PC_W  = fetch_pkg::PC_W,
  parameter int unsigned LUT_W = fetch_pkg::LUT_W,
  parameter int unsigned CNT_W = fetch_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             flag_in,
  input  logic             branch_en,
  input  logic             jump_en,
  input  logic             halt_req,
  input  logic [LUT_W-1:0] lut_idx,
  input  logic             lut_wr_en,
  input  logic [LUT_W-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]  lut_wr_data,
  output logic [PC_W-1:0]  pc_out,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);
  import fetch_pkg::*;

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]  target;
  logic             lut_we;
  logic             taken;

  // The table is only writable while no program is executing.
  assign lut_we = lut_wr_en && (state_q != RUN);
  assign taken  = jump_en || (branch_en && flag_in);

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lut_we),
    .wr_idx  (lut_wr_idx),
    .wr_data (lut_wr_data),
    .rd_idx  (lut_idx),
    .rd_data (target)
  );

  // State, PC and counter update; halt outranks any jump or branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (halt_req) begin
            state_q <= DONE;
          end else if (taken) begin
            pc_q <= target;
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        default: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= start_addr;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, a counter
// saturation sequence, then randomized stimulus against a reference model.
module tb_fetch_ctrl;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned LUT_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SMALL_CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, flag_in, branch_en, jump_en, halt_req, lut_wr_en;
  logic [PC_W-1:0]  start_addr, lut_wr_data;
  logic [LUT_W-1:0] lut_idx, lut_wr_idx;

  logic [PC_W-1:0]        pc_out, pc_out4;
  logic                   running, running4, done, done4;
  logic [CNT_W-1:0]       cycle_count;
  logic [SMALL_CNT_W-1:0] cycle_count4;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: st 0=idle 1=run 2=done, counter kept unbounded.
  int m_st, m_pc, m_cnt;
  int m_lut [32];

  typedef struct {
    bit rst_n, start;
    int saddr;
    bit flag, br, jmp, halt;
    int idx;
    bit we;
    int widx, wdata;
    int epc;
    bit erun, edone;
    int ecnt;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .flag_in(flag_in), .branch_en(branch_en), .jump_en(jump_en), .halt_req(halt_req),
    .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data), .pc_out(pc_out), .running(running), .done(done),
    .cycle_count(cycle_count)
  );

  fetch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(SMALL_CNT_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .flag_in(flag_in), .branch_en(branch_en), .jump_en(jump_en), .halt_req(halt_req),
    .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data), .pc_out(pc_out4), .running(running4), .done(done4),
    .cycle_count(cycle_count4)
  );

  function automatic vec_t mk(bit r, bit s, int sa, bit f, bit b, bit j, bit h, int ix,
                              bit we, int wi, int wd, int epc, bit er, bit ed, int ec);
    vec_t v;
    v.rst_n = r; v.start = s; v.saddr = sa; v.flag = f; v.br = b; v.jmp = j;
    v.halt = h; v.idx = ix; v.we = we; v.widx = wi; v.wdata = wd;
    v.epc = epc; v.erun = er; v.edone = ed; v.ecnt = ec;
    return v;
  endfunction

  function automatic int sat(int c, int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Advance the reference model by one clock edge using the driven inputs.
  task automatic model_step(input vec_t v);
    if (!v.rst_n) begin
      m_st = 0; m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
    end else if (m_st == 1) begin
      m_cnt++;
      if (v.halt) m_st = 2;
      else if (v.jmp || (v.br && v.flag)) m_pc = m_lut[v.idx];
      else m_pc = (m_pc + 1) % (1 << PC_W);
    end else begin
      if (v.we) m_lut[v.widx] = v.wdata;
      if (v.start) begin
        m_st = 1; m_pc = v.saddr; m_cnt = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle past the edge.
  task automatic apply(input vec_t v);
    rst_n       = v.rst_n;
    start       = v.start;
    start_addr  = PC_W'(v.saddr);
    flag_in     = v.flag;
    branch_en   = v.br;
    jump_en     = v.jmp;
    halt_req    = v.halt;
    lut_idx     = LUT_W'(v.idx);
    lut_wr_en   = v.we;
    lut_wr_idx  = LUT_W'(v.widx);
    lut_wr_data = PC_W'(v.wdata);
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int epc, input bit er, input bit ed, input int ec);
    n_vec++;
    if (int'(pc_out) != epc || running != er || done != ed || int'(cycle_count) != sat(ec, CNT_W) ||
        int'(pc_out4) != epc || running4 != er || done4 != ed ||
        int'(cycle_count4) != sat(ec, SMALL_CNT_W)) begin
      n_bad++;
      $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d cnt4=%0d, want pc=%h run=%b done=%b cnt=%0d cnt4=%0d",
               name, pc_out, running, done, cycle_count, cycle_count4,
               epc, er, ed, sat(ec, CNT_W), sat(ec, SMALL_CNT_W));
    end
  endtask

  initial begin
    vec_t v;
    //           rst st saddr  f  b  j  h idx we wi wdata   epc  run done cnt
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h040, 0, 0, 0, 0, 0, 0, 0, 0,     'h040, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h041, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     'h041, 0, 1, 2));
    tbl.push_back(mk(1, 1, 'h3FD, 0, 0, 0, 0, 0, 0, 0, 0,     'h3FD, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h3FE, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h3FF, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h000, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h001, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     'h001, 0, 1, 5));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 1, 3, 'h120, 'h001, 0, 1, 5));
    tbl.push_back(mk(1, 1, 'h010, 0, 0, 0, 0, 0, 0, 0, 0,     'h010, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 1, 0, 0, 3, 0, 0, 0,     'h011, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     1, 1, 0, 0, 3, 0, 0, 0,     'h120, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 0, 3, 0, 0, 0,     'h120, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0,     0, 1, 1, 0, 3, 0, 0, 0,     'h120, 1, 0, 4));
    tbl.push_back(mk(1, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0,     'h121, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 1, 3, 'h2AA, 'h122, 1, 0, 6));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 0, 3, 0, 0, 0,     'h120, 1, 0, 7));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 1, 3, 0, 0, 0,     'h120, 0, 1, 8));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 1, 3, 'h2AA, 'h120, 0, 1, 8));
    tbl.push_back(mk(1, 1, 'h050, 0, 0, 0, 0, 0, 0, 0, 0,     'h050, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 0, 3, 0, 0, 0,     'h2AA, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     'h2AA, 0, 1, 2));
    tbl.push_back(mk(1, 1, 'h054, 0, 0, 0, 0, 0, 0, 0, 0,     'h054, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,     'h055, 1, 0, 1));
    tbl.push_back(mk(0, 1, 'h3AA, 1, 1, 1, 0, 3, 1, 3, 'h111, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h070, 0, 0, 0, 0, 0, 0, 0, 0,     'h070, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 0, 3, 0, 0, 0,     'h000, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     'h000, 0, 1, 2));
    tbl.push_back(mk(1, 1, 'h080, 0, 0, 0, 0, 0, 1, 5, 'h0AB, 'h080, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0, 1, 0, 5, 0, 0, 0,     'h0AB, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     'h0AB, 0, 1, 2));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      check($sformatf("vec%0d", k), tbl[k].epc, tbl[k].erun, tbl[k].edone, tbl[k].ecnt);
    end

    // Counter saturation: 20 RUN cycles; narrow counter must stop at 15.
    v = mk(1, 1, 'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v);
    v.start = 0;
    for (int k = 0; k < 20; k++) apply(v);
    check("sat_run20", 20, 1, 0, 20);
    n_vec++;
    if (cycle_count4 != 4'hF) begin
      n_bad++;
      $display("FAIL sat_cnt4: got %0d want 15", cycle_count4);
    end
    v.halt = 1;
    apply(v);
    check("sat_halt", 20, 0, 1, 21);

    // Randomized phase against the reference model.
    for (int k = 0; k < 3000; k++) begin
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.start = ($urandom_range(0, 11) == 0);
      v.saddr = $urandom_range(0, (1 << PC_W) - 1);
      v.flag  = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 3) == 0);
      v.jmp   = ($urandom_range(0, 7) == 0);
      v.halt  = ($urandom_range(0, 19) == 0);
      v.idx   = $urandom_range(0, 3);
      v.we    = ($urandom_range(0, 3) == 0);
      v.widx  = $urandom_range(0, 3);
      v.wdata = $urandom_range(0, (1 << PC_W) - 1);
      apply(v);
      check($sformatf("rand%0d", k), m_pc, m_st == 1, m_st == 2, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
